// File: rtl/uart_pkg.sv
// Shared UART receive definitions: frame states, default line settings and bit-timing helpers.
// The state set includes PARITY only when UART_RX_PARITY_EN is defined.
package uart_pkg;

  localparam int DEF_CLK_FREQ_HZ = 100_000_000;
  localparam int DEF_BAUD        = 115_200;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3,
    ST_PARITY = 3'd4
  } rx_state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd3
  } rx_state_e;
`endif

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  function automatic int half_bit(input int cpb);
    return cpb / 32'sd2;
  endfunction

endpackage

// File: rtl/uart_rx_bit_timer.sv
// Bit-period counter: loads on start detection, wraps once per bit and strobes at each mid-bit point.
module uart_rx_bit_timer #(
  parameter int CLKS_PER_BIT = 868,
  parameter int HALF_BIT     = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic run_next,
  input  logic load,
  output logic sample_en
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CLKS_PER_BIT - HALF_BIT);

  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_next_s;
  logic             sample_en_r;

  // Next count: preload on start edge, free-run with wrap while framing, park at zero when idle.
  always_comb begin
    count_next_s = count_r;
    if (load) begin
      count_next_s = CNT_LOAD;
    end else if (run) begin
      if (count_r == CNT_MAX) begin
        count_next_s = {CNT_W{1'b0}};
      end else begin
        count_next_s = count_r + CNT_W'(1);
      end
    end else begin
      count_next_s = {CNT_W{1'b0}};
    end
  end

  // The strobe is registered from next-cycle values so it is high exactly while count_r sits at CNT_MAX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r     <= {CNT_W{1'b0}};
      sample_en_r <= 1'b0;
    end else begin
      count_r     <= count_next_s;
      sample_en_r <= run_next & (count_next_s == CNT_MAX);
    end
  end

  assign sample_en = sample_en_r;

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: resynchronises RX, sequences start/data/stop sampling, and
// hands bytes out on valid/ready. Define UART_RX_PARITY_EN to expect an even-parity bit.
module uart_rx_frame_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = DEF_CLK_FREQ_HZ,
  parameter int BAUD        = DEF_BAUD,
  parameter int DATA_BITS   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_rx,
  output logic                 o_sample_en,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_frame_err,
  output logic                 o_overrun,
  output logic                 o_busy
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD);
  localparam int HALF_BIT     = half_bit(CLKS_PER_BIT);
  localparam int IDX_W        = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic rx_meta_r, rx_sync_r, rx_prev_r;
  logic fall_s, load_s, run_s, run_next_s, sample_en_s;
  rx_state_e state_r, state_next_s;
  logic [IDX_W-1:0]     idx_r;
  logic [DATA_BITS-1:0] shift_r;
  logic shift_en_s, deliver_s, ferr_s, par_bad_s;
  logic [DATA_BITS-1:0] data_r;
  logic valid_r, ferr_r, ovr_r, busy_r;
`ifdef UART_RX_PARITY_EN
  logic par_chk_s, par_err_r;
`endif

  // Idle-high resynchroniser followed by the edge register used for start detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= i_rx;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  assign fall_s     = rx_prev_r & ~rx_sync_r;
  assign load_s     = fall_s & (state_r == ST_IDLE);
  assign run_s      = (state_r != ST_IDLE);
  assign run_next_s = (state_next_s != ST_IDLE);

  uart_rx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .HALF_BIT    (HALF_BIT)
  ) u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .run      (run_s),
    .run_next (run_next_s),
    .load     (load_s),
    .sample_en(sample_en_s)
  );

  // Frame state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state and per-strobe actions; every transition out of IDLE waits for a sample strobe.
  always_comb begin
    state_next_s = state_r;
    shift_en_s   = 1'b0;
    deliver_s    = 1'b0;
    ferr_s       = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_chk_s    = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        if (fall_s) begin
          state_next_s = ST_START;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (sample_en_s) begin
          state_next_s = rx_sync_r ? ST_IDLE : ST_DATA;
        end else begin
          state_next_s = ST_START;
        end
      end
      ST_DATA: begin
        if (sample_en_s) begin
          shift_en_s = 1'b1;
          if (idx_r == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_next_s = ST_PARITY;
`else
            state_next_s = ST_STOP;
`endif
          end else begin
            state_next_s = ST_DATA;
          end
        end else begin
          state_next_s = ST_DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (sample_en_s) begin
          par_chk_s    = 1'b1;
          state_next_s = ST_STOP;
        end else begin
          state_next_s = ST_PARITY;
        end
      end
`endif
      ST_STOP: begin
        if (sample_en_s) begin
          state_next_s = ST_IDLE;
          deliver_s    = rx_sync_r & ~par_bad_s;
          ferr_s       = ~rx_sync_r | par_bad_s;
        end else begin
          state_next_s = ST_STOP;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // LSB-first assembly: each sample enters at the MSB so the first bit ends up at bit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_r <= {DATA_BITS{1'b0}};
      idx_r   <= {IDX_W{1'b0}};
    end else if (shift_en_s) begin
      shift_r <= {rx_sync_r, shift_r[DATA_BITS-1:1]};
      idx_r   <= idx_r + IDX_W'(1);
    end else if (state_r == ST_START) begin
      idx_r   <= {IDX_W{1'b0}};
    end
  end

`ifdef UART_RX_PARITY_EN
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

  // Parity verdict latched at the parity strobe and held until the stop bit decides delivery.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_err_r <= 1'b0;
    end else if (state_r == ST_START) begin
      par_err_r <= 1'b0;
    end else if (par_chk_s) begin
      par_err_r <= rx_sync_r ^ even_parity(shift_r);
    end
  end

  assign par_bad_s = par_err_r;
`else
  assign par_bad_s = 1'b0;
`endif

  // Output handshake: a pending byte is never overwritten; a same-cycle accept frees the slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_r  <= {DATA_BITS{1'b0}};
      valid_r <= 1'b0;
      ferr_r  <= 1'b0;
      ovr_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      busy_r <= run_next_s;
      ferr_r <= ferr_s;
      ovr_r  <= 1'b0;
      if (deliver_s) begin
        if (!valid_r || i_ready) begin
          data_r  <= shift_r;
          valid_r <= 1'b1;
        end else begin
          ovr_r   <= 1'b1;
        end
      end else if (valid_r && i_ready) begin
        valid_r <= 1'b0;
      end
    end
  end

  assign o_sample_en = sample_en_s;
  assign o_data      = data_r;
  assign o_valid     = valid_r;
  assign o_frame_err = ferr_r;
  assign o_overrun   = ovr_r;
  assign o_busy      = busy_r;

endmodule

// File: doc/uart_rx_frame_ctrl.md
# uart_rx_frame_ctrl

UART receive frame controller: resynchronises the serial line, detects start edges, schedules mid-bit sampling strobes from an internal bit timer, and assembles bits into bytes. Delivers each byte on a valid/ready handshake with framing-error and overrun flags. Sits between the board RX pin and byte-level consumers, replacing free-running sample-enable generation with frame-aware sequencing.

## Interface
- CLK_FREQ_HZ, 100_000_000, system clock frequency
- BAUD, 115200, line rate
- DATA_BITS, 8, data bits per frame (5..8), LSB first
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- i_rx  in  1  raw serial line, asynchronous, idle high
- o_sample_en  out  1  one-cycle strobe at each mid-bit sample point
- o_data  out  DATA_BITS  received byte; stable while o_valid high
- o_valid  out  1  byte available; held until accepted
- i_ready  in  1  consumer accepts byte when o_valid & i_ready
- o_frame_err  out  1  one-cycle pulse: stop bit sampled low
- o_overrun  out  1  one-cycle pulse: byte completed while o_valid still pending
- o_busy  out  1  high in any state other than IDLE

## Operation
- Derived constants: CLKS_PER_BIT = CLK_FREQ_HZ/BAUD (integer truncation, 868 default); HALF_BIT = CLKS_PER_BIT/2 (434). Counter width = $clog2(CLKS_PER_BIT).
- i_rx passes a 2-flop synchroniser (reset value 1) then an edge register; logic uses the synchronised value only.
- States: IDLE, START, DATA, PARITY (macro only), STOP.
- IDLE: on synchronised 1->0 transition, load bit counter with CLKS_PER_BIT-HALF_BIT, go START.
- Bit timer: increments each cycle outside IDLE; at CLKS_PER_BIT-1 wraps to 0 and asserts o_sample_en that cycle. First strobe is HALF_BIT cycles after edge detection; subsequent strobes every CLKS_PER_BIT.
- START: on strobe, sample low -> DATA, bit index 0; sample high -> glitch, back to IDLE, nothing reported.
- DATA: on each strobe shift sample into MSB of shift register; after DATA_BITS strobes -> PARITY or STOP.
- STOP: on strobe, sample high -> deliver byte; sample low -> pulse o_frame_err, discard byte. Either way go IDLE the same cycle (next start edge may be detected immediately).
- Delivery: if o_valid low, or o_valid & i_ready in the same cycle, load o_data and set o_valid. Otherwise pulse o_overrun, drop new byte, keep old o_data/o_valid.
- o_valid clears on the cycle after o_valid & i_ready unless a new byte loads that cycle.
- Reset values: o_sample_en 0, o_data 0, o_valid 0, o_frame_err 0, o_overrun 0, o_busy 0, state IDLE, timer 0.
- Reset mid-frame: frame abandoned, no flags; first post-reset frame requires line high then a fresh falling edge.

## Timing
- Synchroniser latency 2 cycles; edge detection +1 cycle.
- o_valid rises 1 cycle after the stop-bit strobe: DATA_BITS*CLKS_PER_BIT + CLKS_PER_BIT + HALF_BIT + 1 cycles after edge detection (8247 default).
- o_frame_err/o_overrun pulse coincides with o_valid update cycle (1 cycle after stop strobe).
- o_sample_en never asserted in IDLE.

## Configuration
- UART_RX_PARITY_EN defined: PARITY state inserted after DATA, even parity over data bits; mismatch pulses o_frame_err and discards byte; STOP still sampled. Latency grows by CLKS_PER_BIT.
- Undefined: no PARITY state, 8N1-style frames only; no parity logic synthesised.

## Structure
- Shared package uart_pkg: state enum type, CLKS_PER_BIT/HALF_BIT computation functions, default CLK_FREQ_HZ/BAUD.
- One sub-module: uart_rx_bit_timer (counter, load-on-start, strobe output), instantiated once; FSM, shift register and output handshake stay in the top.

## Test plan
- Frame 0xA5 at 115200, i_ready=1 -> o_valid high 8247 cycles after edge detect, o_data=0xA5, 10 o_sample_en strobes spaced 868 (first 434).
- 100-cycle low glitch on idle line -> no o_valid, no flags, o_busy low from cycle 435.
- Frame 0x3C with stop bit low -> o_frame_err one-cycle pulse, o_valid stays 0.
- Frames 0x11 then 0x22 back-to-back, i_ready=0 -> o_data=0x11 retained, o_overrun pulse at second stop; then i_ready=1 and 0x33 -> accepted, o_data=0x33.
- rst asserted mid DATA of 0xFF, released, then frame 0x5A -> only 0x5A delivered, no flags.
- With UART_RX_PARITY_EN: 0x07 with parity 1 -> delivered; with parity 0 -> o_frame_err pulse, no o_valid.
